// File: rtl/dense_argmax_reader_pkg.sv
// dense_reader_pkg: state encoding and CIFAR-10 classifier head sizes shared by the argmax reader.
package dense_reader_pkg;

    localparam int CIFAR10_NUM_CLASSES = 10;
    localparam int CIFAR10_SCORE_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_READ      = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_RESULT    = 3'd5
    } reader_state_e;

endpackage

// File: rtl/dense_argmax_reader_if.sv
// dense_argmax_reader_if: dense-layer start/done/read port plus the valid/ready result port.
interface dense_argmax_reader_if
    import dense_reader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = CIFAR10_SCORE_W
);

    logic              layer_start;
    logic              layer_done;
    logic [ADDR_W-1:0] layer_read_addr;
    logic [DATA_W-1:0] layer_read_data;
    logic [ADDR_W-1:0] class_id;
    logic [DATA_W-1:0] class_score;
    logic              result_valid;
    logic              result_ready;

    modport master (
        output layer_start, layer_read_addr, class_id, class_score, result_valid,
        input  layer_done, layer_read_data, result_ready
    );

    modport slave (
        input  layer_start, layer_read_addr, class_id, class_score, result_valid,
        output layer_done, layer_read_data, result_ready
    );

endinterface

// File: rtl/dense_argmax_reader_argmax_accum.sv
// argmax_accum: running signed maximum with index; the first sample (init) loads unconditionally, ties keep the earlier index.
module argmax_accum
    import dense_reader_pkg::*;
#(
    parameter int DATA_W = CIFAR10_SCORE_W,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] max,
    output logic [IDX_W-1:0]  max_idx
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            max     <= '0;
            max_idx <= '0;
        end else if (valid && (init || $signed(data) > $signed(max))) begin
            max     <= data;
            max_idx <= idx;
        end
    end

endmodule

// File: rtl/dense_argmax_reader.sv
// dense_argmax_reader: launches the dense layer, sweeps its scores through a running argmax and hands back the winner.
// Define DENSE_ARGMAX_READER_TIMEOUT_EN to add the layer_done watchdog and the sticky timeout_err output.
module dense_argmax_reader
    import dense_reader_pkg::*;
#(
    parameter int NUM_CLASSES    = CIFAR10_NUM_CLASSES,
    parameter int DATA_W         = CIFAR10_SCORE_W,
    parameter int ADDR_W         = 4,
    parameter int RD_LAT         = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic resetn,
    input  logic req,
    output logic busy,
`ifdef DENSE_ARGMAX_READER_TIMEOUT_EN
    output logic timeout_err,
`endif
    dense_argmax_reader_if.master bus
);

    localparam logic [2:0] IDLE      = ST_IDLE;
    localparam logic [2:0] START     = ST_START;
    localparam logic [2:0] WAIT_DONE = ST_WAIT_DONE;
    localparam logic [2:0] READ      = ST_READ;
    localparam logic [2:0] DRAIN     = ST_DRAIN;
    localparam logic [2:0] RESULT    = ST_RESULT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CLASSES - 1);

    if (RD_LAT < 0 || RD_LAT > 2) begin : g_bad_lat
        $error("RD_LAT must be 0..2");
    end
    if ((1 << ADDR_W) < NUM_CLASSES) begin : g_bad_addr
        $error("ADDR_W too narrow for NUM_CLASSES");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    logic [2:0]        state;
    logic              guard;
    logic [1:0]        drain_cnt;
    logic [ADDR_W-1:0] addr;
    logic              rd_last;
    logic              done_seen;
    logic              wd_fire;
    logic              cap_valid;
    logic [ADDR_W-1:0] cap_idx;

    assign rd_last   = addr == LAST;
    // a done still high from the previous run is masked for one cycle after START
    assign done_seen = !guard && bus.layer_done;

    assign busy                = state != IDLE;
    assign bus.layer_start     = state == START;
    assign bus.result_valid    = state == RESULT;
    assign bus.layer_read_addr = addr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            guard     <= 1'b0;
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            guard <= state == START;
            case (state)
                IDLE:      if (req) state <= START;
                START:     state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (done_seen) state <= READ;
                    else if (wd_fire) state <= IDLE;
                end
                READ: begin
                    addr <= !rd_last ? addr + 1'b1 : (RD_LAT == 0 ? '0 : addr);
                    if (rd_last) state <= (RD_LAT == 0) ? RESULT : DRAIN;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == 2'(RD_LAT - 1)) begin
                        state     <= RESULT;
                        addr      <= '0;
                        drain_cnt <= '0;
                    end
                end
                RESULT:    if (bus.result_valid && bus.result_ready) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

`ifdef DENSE_ARGMAX_READER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_fire = state == WAIT_DONE && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1) && !done_seen;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
            if (state == IDLE && req) timeout_err <= 1'b0;
            else if (wd_fire) timeout_err <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // address/valid tags follow the read data through the layer's RD_LAT pipeline
    if (RD_LAT == 0) begin : g_nolat
        assign cap_valid = state == READ;
        assign cap_idx   = addr;
    end else begin : g_lat
        logic [RD_LAT-1:0] vp;
        logic [ADDR_W-1:0] ip [RD_LAT];
        always_ff @(posedge clk) begin
            if (!resetn) begin
                vp <= '0;
                ip <= '{default: '0};
            end else begin
                for (int i = RD_LAT - 1; i > 0; i--) begin
                    vp[i] <= vp[i-1];
                    ip[i] <= ip[i-1];
                end
                vp[0] <= state == READ;
                ip[0] <= addr;
            end
        end
        assign cap_valid = vp[RD_LAT-1];
        assign cap_idx   = ip[RD_LAT-1];
    end

    argmax_accum #(
        .DATA_W(DATA_W),
        .IDX_W (ADDR_W)
    ) u_accum (
        .clk    (clk),
        .resetn (resetn),
        .init   (cap_idx == '0),
        .valid  (cap_valid),
        .data   (bus.layer_read_data),
        .idx    (cap_idx),
        .max    (bus.class_score),
        .max_idx(bus.class_id)
    );

endmodule

// File: tb/tb_dense_argmax_reader.sv
// tb_dense_argmax_reader: scoreboarded random and directed readouts against an array-based argmax model.
module tb_dense_argmax_reader;
    import dense_reader_pkg::*;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int RL = 1;
    localparam int TO = 50;

    typedef struct {
        logic [AW-1:0] id;
        logic [DW-1:0] score;
    } res_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic req = 1'b0;
    logic busy;
`ifdef DENSE_ARGMAX_READER_TIMEOUT_EN
    logic timeout_err;
`endif
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    res_t q[$];
    logic [DW-1:0] mem [N];

    dense_argmax_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dense_argmax_reader #(
        .NUM_CLASSES   (N),
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .RD_LAT        (RL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .busy       (busy),
`ifdef DENSE_ARGMAX_READER_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // layer model: registered read, one cycle of latency
    always @(posedge clk)
        bus.layer_read_data <= (int'(bus.layer_read_addr) < N) ? mem[bus.layer_read_addr] : '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_layer_start"}, bus.layer_start, 0);
        check({tag, "_read_addr"}, bus.layer_read_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_result_valid"}, bus.result_valid, 0);
        check({tag, "_class_id"}, bus.class_id, 0);
        check({tag, "_class_score"}, bus.class_score, 0);
`ifdef DENSE_ARGMAX_READER_TIMEOUT_EN
        check({tag, "_timeout_err"}, timeout_err, 0);
`endif
    endtask

    // monitor: every cycle the result is offered it must equal the oldest expectation
    always @(negedge clk) begin
        if (resetn && bus.result_valid) begin
            check("sb_has_entry", q.size() != 0, 1);
            if (q.size() != 0) begin
                check("class_id", bus.class_id, q[0].id);
                check("class_score", bus.class_score, q[0].score);
                if (bus.result_ready) void'(q.pop_front());
            end
        end
    end

    task automatic run_once(input int dly, input bit pulse, input int hold, input bit poke);
        int   s, d, best, n;
        bit   stale;
        res_t e;
        best = 0;
        for (int k = 1; k < N; k++)
            if ($signed(mem[k]) > $signed(mem[best])) best = k;
        e.id    = AW'(best);
        e.score = mem[best];
        q.push_back(e);
        stale = bus.layer_done;
        bus.result_ready = (hold == 0);
        req = 1'b1;
        step();
        req = 1'b0;
        s = cyc;
        check("start_pulse", bus.layer_start, 1);
        check("busy_rise", busy, 1);
`ifdef DENSE_ARGMAX_READER_TIMEOUT_EN
        check("timeout_err_cleared", timeout_err, 0);
`endif
        step();
        check("start_once", bus.layer_start, 0);
        if (stale) d = s + 2;
        else begin
            repeat (dly - 1) step();
            bus.layer_done = 1'b1;
            d = (dly < 2) ? s + 2 : s + dly;
            if (pulse) begin
                step();
                bus.layer_done = 1'b0;
            end
        end
        n = 0;
        while (!bus.result_valid && n < 60) begin
            step();
            n++;
        end
        check("valid_latency", cyc, d + N + RL + 1);
        for (int i = 0; i < hold; i++) begin
            req = poke;
            step();
        end
        bus.result_ready = 1'b1;
        req = poke;
        step();
        req = 1'b0;
        bus.result_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_no_start", bus.layer_start, 0);
        check("idle_valid", bus.result_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n, dly, ties;
        bus.layer_done   = 1'b0;
        bus.result_ready = 1'b0;
        repeat (3) step();
        check_reset_vals("reset");
        resetn = 1'b1;
        step();

        mem = '{32'd5, -32'sd3, 32'd12, 32'd7, 32'd0, 32'd12, -32'sd100, 32'd1, 32'd2, 32'd3};
        run_once(2, 1'b1, 0, 1'b0);

        for (int k = 0; k < N; k++) mem[k] = 32'h8000_0000;
        run_once(3, 1'b0, 0, 1'b0);

        // done is still high from the level run above: the guard cycle must mask it
        for (int k = 0; k < N; k++) mem[k] = $urandom;
        run_once(1, 1'b0, 0, 1'b0);
        bus.layer_done = 1'b0;

        for (int k = 0; k < N; k++) mem[k] = $urandom;
        run_once(2, 1'b1, 20, 1'b1);
        for (int k = 0; k < N; k++) mem[k] = $urandom;
        run_once(2, 1'b1, 0, 1'b0);

        for (int k = 0; k < N; k++) mem[k] = $urandom;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        bus.layer_done = 1'b1;
        step();
        step();
        bus.layer_done = 1'b0;
        n = 0;
        while (bus.layer_read_addr != 4'd5 && n < 40) begin
            step();
            n++;
        end
        check("reached_addr5", bus.layer_read_addr, 5);
        resetn = 1'b0;
        step();
        check_reset_vals("midread");
        resetn = 1'b1;
        for (int k = 0; k < N; k++) mem[k] = $urandom;
        run_once(2, 1'b1, 1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            ties = $urandom_range(0, 1);
            for (int k = 0; k < N; k++)
                mem[k] = (ties != 0) ? DW'($urandom_range(0, 3)) - DW'(2) : DW'($urandom);
            dly = $urandom_range(1, 5);
            run_once(dly, (dly >= 2) && ($urandom_range(0, 1) != 0), $urandom_range(0, 3), $urandom_range(0, 1) != 0);
            if ($urandom_range(0, 1) != 0) bus.layer_done = 1'b0;
        end

`ifdef DENSE_ARGMAX_READER_TIMEOUT_EN
        bus.layer_done = 1'b0;
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        repeat (TO) step();
        check("wd_busy_before", busy, 1);
        step();
        check("wd_busy_after", busy, 0);
        check("wd_err_set", timeout_err, 1);
        repeat (3) step();
        check("wd_err_sticky", timeout_err, 1);
        for (int k = 0; k < N; k++) mem[k] = $urandom;
        run_once(2, 1'b1, 0, 1'b0);
`endif

        repeat (3) step();
        check("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dense_argmax_reader.md
# dense_argmax_reader

Host-side controller for the final dense layer's start/done/read port, i.e. the 128→10 classifier. It launches the layer, waits for completion, and sweeps the result addresses. It streams the ten signed 32-bit scores through a running argmax and presents the winning class index and score on a valid/ready output. It sits between the RISC-V SoC control path and the CNN accelerator's last layer, and replaces software polling of the scores.

## Interface
Parameters:
- NUM_CLASSES, 10, number of scores read (addresses 0..NUM_CLASSES-1)
- DATA_W, 32, score width; two's-complement signed
- ADDR_W, 4, read address width; must satisfy 2^ADDR_W ≥ NUM_CLASSES
- RD_LAT, 1, cycles from layer_read_addr to valid layer_read_data; legal values 0..2
- TIMEOUT_CYCLES, 65535, done watchdog limit; used only when the watchdog is compiled in

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  synchronous, active-low reset
- req  in  1  one-cycle request to run one inference readout
- busy  out  1  high from the cycle after an accepted req until result handshake completes
- layer_start  out  1  one-cycle start pulse to the dense layer
- layer_done  in  1  completion flag from the layer; may be a level or a pulse
- layer_read_addr  out  ADDR_W  score address
- layer_read_data  in  DATA_W  score at layer_read_addr, RD_LAT cycles later
- class_id  out  ADDR_W  argmax index
- class_score  out  DATA_W  score at class_id
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- timeout_err  out  1  watchdog fired; exists only with the macro defined

## Operation
- FSM states: IDLE → START → WAIT_DONE → READ → DRAIN → RESULT → IDLE.
- IDLE: req=1 moves to START. req is ignored in every other state.
- START: layer_start=1 for exactly one cycle. Then go to WAIT_DONE.
- WAIT_DONE: the first cycle is a guard in which layer_done is ignored, because a stale done from the previous run may still be high. From the second cycle, layer_done=1 moves to READ.
- READ: layer_read_addr steps 0,1,…,NUM_CLASSES-1, one address per cycle. After the last address, go to DRAIN.
- DRAIN: lasts RD_LAT cycles; with RD_LAT=0 it is skipped. layer_read_addr holds NUM_CLASSES-1.
- Argmax:
  - Score k is captured when it arrives.
  - Score 0 unconditionally initialises max/idx.
  - Later scores replace max only on signed strict greater-than. Ties keep the lower index.
  - No arithmetic beyond the compare; no width growth.
- RESULT:
  - result_valid=1. class_id and class_score are stable until result_valid && result_ready.
  - On the handshake, go to IDLE and drop busy.
- Outside READ/DRAIN, layer_read_addr returns to 0.
- Reset at any point: all state cleared, FSM to IDLE, no layer_start issued. The partial result is discarded.

## Timing
- Reset values: layer_start=0, layer_read_addr=0, busy=0, result_valid=0, class_id=0, class_score=0, timeout_err=0.
- req sampled at cycle t:
  - layer_start=1 at t+1.
  - busy=1 from t+1.
- layer_done first sampled high at cycle d:
  - address k driven at d+1+k.
  - its data is captured at d+1+k+RD_LAT.
  - result_valid rises at d+NUM_CLASSES+RD_LAT+1. Defaults: d+12.
- result_ready high at or before result_valid: handshake in that cycle. Next cycle is IDLE, and a new req is accepted there.
- req and handshake in the same cycle: req is ignored, because the FSM is not yet in IDLE.
- Minimum request-to-request period with an instant-done layer and defaults: 16 cycles.

## Configuration
- DENSE_ARGMAX_READER_TIMEOUT_EN defined:
  - A counter runs in WAIT_DONE.
  - Reaching TIMEOUT_CYCLES without done goes to IDLE, sets sticky timeout_err=1, drops busy, and produces no result.
  - The next accepted req clears timeout_err.
- Not defined: no counter and no timeout_err port. WAIT_DONE waits indefinitely.

## Structure
- Package dense_reader_pkg holds:
  - state enum typedef.
  - CIFAR10_NUM_CLASSES=10.
  - CIFAR10_SCORE_W=32.
- Sub-module argmax_accum (init, valid, data, idx in; max, max_idx out): the running signed compare. It is reusable for other classifier heads.

## Test plan
- Scores {5,-3,12,7,0,12,-100,1,2,3}, RD_LAT=1 → class_id=2, class_score=12; result_valid exactly 12 cycles after done.
- All scores -2147483648 → class_id=0, class_score=-2147483648. Checks signed compare and tie rule.
- Stale layer_done held high through START → guard cycle ignores it. Reads begin only after done is sampled in the second WAIT_DONE cycle.
- result_ready held low 20 cycles, req pulsed during RESULT → outputs stable, req ignored. Handshake then IDLE, and a next req accepted.
- resetn low mid-READ at address 5 → next cycle all outputs at reset values. A subsequent req performs a clean full run.
- Macro defined, TIMEOUT_CYCLES=50, done never asserted → timeout_err=1 and busy=0 at 50 WAIT_DONE cycles. Next req clears timeout_err.
